input_debounce2: RTL and testbench

INPUT_DEBOUNCE2 -- requirements
Module: input_debounce2

---
 rtl/input_debounce2_pkg.sv | 18 +
 rtl/input_debounce2_debounce_ch.sv | 105 ++++++++++
 rtl/input_debounce2.sv | 36 +++
 tb/tb_input_debounce2.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/input_debounce2_pkg.sv
// Shared types for the two-channel debouncer: FSM state encoding and counter width.
package input_debounce2_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } db_state_e;

  // Debounced level implied by a state: high while stable-high or while a fall is pending.
  function automatic logic state_is_high(input db_state_e s);
    return (s == STABLE_HI) || (s == WAIT_LO);
  endfunction

endpackage

// File: rtl/input_debounce2_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, hold-time FSM with 8-bit counter,
// registered level and one-cycle change pulse.
module debounce_ch
  import input_debounce2_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic db_o,
  output logic edge_o
);

  localparam logic [CNT_W-1:0] DebLimit = CNT_W'(DEB_CYCLES);

  logic             s1_q, s2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             edge_q, edge_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      STABLE_LO: begin
        if (s2_q) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s2_q) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == DebLimit) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!s2_q) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s2_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == DebLimit) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Level is registered from the next state so it moves on the same edge as the FSM.
  always_comb begin
    db_d   = state_is_high(state_d);
    edge_d = db_d ^ db_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      edge_q  <= edge_d;
    end
  end

  assign db_o   = db_q;
  assign edge_o = edge_q;

endmodule

// File: rtl/input_debounce2.sv
// Two independent debounce channels feeding a downstream gate, plus a combined edge flag.
module input_debounce2
  import input_debounce2_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_db,
  output logic b_db,
  output logic a_edge,
  output logic b_edge,
  output logic any_edge
);

  debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_ch_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .raw_i  (a_raw),
    .db_o   (a_db),
    .edge_o (a_edge)
  );

  debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_ch_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .raw_i  (b_raw),
    .db_o   (b_db),
    .edge_o (b_edge)
  );

  assign any_edge = a_edge | b_edge;

endmodule

// File: tb/tb_input_debounce2.sv
// Bench for input_debounce2 at DEB_CYCLES=4 and DEB_CYCLES=1 sharing one stimulus stream.
module tb_input_debounce2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;

  logic a_db4, b_db4, a_edge4, b_edge4, any4;
  logic a_db1, b_db1, a_edge1, b_edge1, any1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  input_debounce2 #(.DEB_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a_raw(a_raw), .b_raw(b_raw),
    .a_db(a_db4), .b_db(b_db4), .a_edge(a_edge4), .b_edge(b_edge4), .any_edge(any4)
  );

  input_debounce2 #(.DEB_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a_raw(a_raw), .b_raw(b_raw),
    .a_db(a_db1), .b_db(b_db1), .a_edge(a_edge1), .b_edge(b_edge1), .any_edge(any1)
  );

  // Reference: a level is accepted once the last DEB+1 synchronised samples all
  // disagree with the current debounced level (sample window, not a state machine).
  int          deb[2] = '{4, 1};
  logic        m_s1[2][2];
  logic        m_s2[2][2];
  logic [15:0] m_win[2][2];
  logic        m_db[2][2];
  logic        m_edge[2][2];

  logic [4:0] expq4[$];
  logic [4:0] expq1[$];

  task automatic model_step(input int d, input logic ra, input logic rb, input logic rn,
                            output logic [4:0] e);
    logic        r[2];
    logic [15:0] mask;
    logic [15:0] target;
    r[0] = ra;
    r[1] = rb;
    mask = 16'((1 << (deb[d] + 1)) - 1);
    for (int c = 0; c < 2; c++) begin
      if (!rn) begin
        m_s1[d][c]   = 1'b0;
        m_s2[d][c]   = 1'b0;
        m_win[d][c]  = '0;
        m_db[d][c]   = 1'b0;
        m_edge[d][c] = 1'b0;
      end else begin
        m_win[d][c] = {m_win[d][c][14:0], m_s2[d][c]};
        target = m_db[d][c] ? 16'h0000 : mask;
        if ((m_win[d][c] & mask) == target) begin
          m_db[d][c]   = ~m_db[d][c];
          m_edge[d][c] = 1'b1;
        end else begin
          m_edge[d][c] = 1'b0;
        end
        m_s2[d][c] = m_s1[d][c];
        m_s1[d][c] = r[c];
      end
    end
    e = {m_db[d][0], m_db[d][1], m_edge[d][0], m_edge[d][1], m_edge[d][0] | m_edge[d][1]};
  endtask

  always @(posedge clk) begin
    logic [4:0] e;
    model_step(0, a_raw, b_raw, rst_n, e);
    expq4.push_back(e);
    model_step(1, a_raw, b_raw, rst_n, e);
    expq1.push_back(e);
  end

  always @(negedge clk) begin
    logic [4:0] got;
    logic [4:0] exp;
    got = {a_db4, b_db4, a_edge4, b_edge4, any4};
    vectors++;
    if (expq4.size() == 0) begin
      miscompares++;
      $display("FAIL deb4 t=%0t no expected entry, got db/edge=%b", $time, got);
    end else begin
      exp = expq4.pop_front();
      if (got !== exp) begin
        miscompares++;
        $display("FAIL deb4 t=%0t {a_db,b_db,a_edge,b_edge,any} got=%b exp=%b", $time, got, exp);
      end
    end
    got = {a_db1, b_db1, a_edge1, b_edge1, any1};
    vectors++;
    if (expq1.size() == 0) begin
      miscompares++;
      $display("FAIL deb1 t=%0t no expected entry, got db/edge=%b", $time, got);
    end else begin
      exp = expq1.pop_front();
      if (got !== exp) begin
        miscompares++;
        $display("FAIL deb1 t=%0t {a_db,b_db,a_edge,b_edge,any} got=%b exp=%b", $time, got, exp);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    $monitor("Time=%0t | a_raw=%b | b_raw=%b | a_db=%b | b_db=%b | any_edge=%b",
             $time, a_raw, b_raw, a_db4, b_db4, any4);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Single rise on A, then fall.
    a_raw = 1'b1; cyc(12);
    a_raw = 1'b0; cyc(12);

    // Short B pulse (3 cycles) that DEB=4 must reject.
    b_raw = 1'b1; cyc(3);
    b_raw = 1'b0; cyc(10);

    // Simultaneous rise and fall on both channels.
    a_raw = 1'b1; b_raw = 1'b1; cyc(12);
    a_raw = 1'b0; b_raw = 1'b0; cyc(12);

    // Reset in the middle of a pending fall on A.
    a_raw = 1'b1; cyc(10);
    a_raw = 1'b0; cyc(5);
    rst_n = 1'b0; cyc(2);
    rst_n = 1'b1; cyc(10);

    // Raw input already high across reset release.
    a_raw = 1'b1;
    rst_n = 1'b0; cyc(2);
    rst_n = 1'b1; cyc(12);
    a_raw = 1'b0; cyc(12);

    // One-cycle glitch on B, then a clean B rise.
    b_raw = 1'b1; cyc(1);
    b_raw = 1'b0; cyc(8);
    b_raw = 1'b1; cyc(8);
    b_raw = 1'b0; cyc(8);

    // Randomised toggling with run lengths around the debounce window, rare resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) a_raw = ~a_raw;
      if ($urandom_range(0, 5) == 0) b_raw = ~b_raw;
      rst_n = ($urandom_range(0, 199) != 0);
      cyc(1);
    end

    rst_n = 1'b1;
    a_raw = 1'b0;
    b_raw = 1'b0;
    cyc(12);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
